cassette_fsk_player: RTL and testbench



---
 rtl/cas_pkg.sv | 18 +
 rtl/cas_bit_timer.sv | 33 +++
 rtl/cassette_fsk_player.sv | 168 ++++++++++++++++
 tb/tb_cassette_fsk_player.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// rtl/cas_pkg.sv - shared constants and state encoding for the cassette FSK player
package cas_pkg;

   localparam int Q_HZ          = 894886;
   localparam int ADDR_W_DEF    = 16;
   localparam int HALF0_DEF     = 373;
   localparam int HALF1_DEF     = 186;
   localparam int RAM_LAT_DEF   = 2;
   localparam int MOTOR_DLY_DEF = 44744;
   localparam int CNT_W         = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_HI    = 3'd2;
   localparam logic [2:0] ST_LO    = 3'd3;
   localparam logic [2:0] ST_EOT   = 3'd4;

endpackage

// File: rtl/cas_bit_timer.sv
// rtl/cas_bit_timer.sv - Q-tick counter producing a terminal-count pulse after half ticks
module cas_bit_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         q_en,
   input  logic         start,
   input  logic         pause,
   input  logic [W-1:0] half,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc = q_en & ~start & ~pause & (cnt_q == half - 1'b1);

   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = '0;
      else if (q_en && !pause)
         cnt_d = tc ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cassette_fsk_player.sv
// rtl/cassette_fsk_player.sv - CAS image byte serializer to 1200/2400 Hz FSK cassette signal
// Optional motor spin-up delay: CAS_MOTOR_DELAY_EN
module cassette_fsk_player
   import cas_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int HALF0   = HALF0_DEF,
   parameter int HALF1   = HALF1_DEF,
   parameter int RAM_LAT = RAM_LAT_DEF
`ifdef CAS_MOTOR_DELAY_EN
   ,
   parameter int MOTOR_DLY = MOTOR_DLY_DEF
`endif
) (
   input  logic              clk,
   input  logic              COCO_RESET_N,
   input  logic              q_en,
   input  logic              relay,
   input  logic              rewind,
   input  logic              loading,
   input  logic [ADDR_W-1:0] tape_len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              casdout,
   output logic              playing,
   output logic              eot
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_q, bit_d;
   logic [3:0]        wait_q, wait_d;
   logic              clear, run, in_bit, bit_tc;
   logic [CNT_W-1:0]  half;

   assign clear    = rewind | loading;
   assign in_bit   = (state_q == ST_HI) | (state_q == ST_LO);
   assign half     = shift_q[0] ? CNT_W'(HALF1) : CNT_W'(HALF0);
   assign addr_inc = addr_q + 1'b1;

`ifdef CAS_MOTOR_DELAY_EN
   logic relay_q, relay_d, dly_q, dly_d, dly_rise, dly_tc;

   // the rise cycle itself must not advance, so it is folded into run
   assign dly_rise = relay & ~relay_q & (state_q != ST_EOT);
   assign run      = relay & ~dly_q & ~dly_rise;

   always_comb begin
      relay_d = relay;
      dly_d   = dly_q;
      if (clear || !relay)
         dly_d = 1'b0;
      else if (dly_rise)
         dly_d = 1'b1;
      else if (dly_tc)
         dly_d = 1'b0;
   end

   cas_bit_timer #(.W(CNT_W)) u_motor_timer (
      .clk   (clk),
      .rst_n (COCO_RESET_N),
      .q_en  (q_en),
      .start (clear | ~relay | ~dly_q),
      .pause (1'b0),
      .half  (CNT_W'(MOTOR_DLY)),
      .tc    (dly_tc)
   );

   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         relay_q <= 1'b0;
         dly_q   <= 1'b0;
      end else begin
         relay_q <= relay_d;
         dly_q   <= dly_d;
      end
   end
`else
   assign run = relay;
`endif

   cas_bit_timer #(.W(CNT_W)) u_bit_timer (
      .clk   (clk),
      .rst_n (COCO_RESET_N),
      .q_en  (q_en),
      .start (clear),
      .pause (~run | ~in_bit),
      .half  (half),
      .tc    (bit_tc)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      wait_d  = wait_q;
      if (clear) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         bit_d   = '0;
         wait_d  = '0;
      end else if (!run) begin
         wait_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tape_len != '0) begin
                  state_d = ST_FETCH;
                  wait_d  = '0;
               end
            end
            ST_FETCH: begin
               if (wait_q == 4'(RAM_LAT)) begin
                  shift_d = rd_data;
                  bit_d   = '0;
                  state_d = ST_HI;
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end
            ST_HI: begin
               if (bit_tc)
                  state_d = ST_LO;
            end
            ST_LO: begin
               if (bit_tc) begin
                  if (bit_q != 3'd7) begin
                     shift_d = {1'b0, shift_q[7:1]};
                     bit_d   = bit_q + 3'd1;
                     state_d = ST_HI;
                  end else begin
                     addr_d  = addr_inc;
                     wait_d  = '0;
                     state_d = (addr_inc == tape_len) ? ST_EOT : ST_FETCH;
                  end
               end
            end
            ST_EOT: begin
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         wait_q  <= wait_d;
      end
   end

   assign rd_addr = addr_q;
   assign casdout = (state_q == ST_HI) & run;
   assign playing = in_bit & relay;
   assign eot     = (state_q == ST_EOT);

endmodule

// File: tb/tb_cassette_fsk_player.sv
// tb/tb_cassette_fsk_player.sv - self-checking bench for cassette_fsk_player
module tb_cassette_fsk_player;

   localparam int HALF0   = 6;
   localparam int HALF1   = 3;
   localparam int RAM_LAT = 2;
`ifdef CAS_MOTOR_DELAY_EN
   localparam int DLY_Q = 10;
`else
   localparam int DLY_Q = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        q_en = 1'b0;
   logic        relay = 1'b0;
   logic        rewind = 1'b0;
   logic        loading = 1'b0;
   logic [15:0] tape_len = 16'd0;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        casdout, playing, eot;

   logic [7:0]  mem [0:255];
   logic [15:0] ram_addr;

   int          checks = 0;
   int          errors = 0;
   int          runs[$];
   int          cur_ph = -1;
   int          cur_len = 0;
   int          gap = 8;
   int          skip = 0;
   int          qcnt = 0;
   logic        relay_prev = 1'b0;
   logic [15:0] prev_addr = 16'd0;

   always #5 clk = ~clk;

   // image RAM: address register followed by a synchronous read
   always @(posedge clk) begin
      ram_addr <= rd_addr;
      rd_data  <= mem[ram_addr[7:0]];
   end

   cassette_fsk_player #(
      .ADDR_W  (16),
      .HALF0   (HALF0),
      .HALF1   (HALF1),
      .RAM_LAT (RAM_LAT)
`ifdef CAS_MOTOR_DELAY_EN
      ,
      .MOTOR_DLY (DLY_Q)
`endif
   ) dut (
      .clk          (clk),
      .COCO_RESET_N (rst_n),
      .q_en         (q_en),
      .relay        (relay),
      .rewind       (rewind),
      .loading      (loading),
      .tape_len     (tape_len),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .casdout      (casdout),
      .playing      (playing),
      .eot          (eot)
   );

   task automatic chk(input string tag, input integer obs, input integer exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic record(input int ph);
      if (ph == cur_ph) begin
         cur_len++;
      end else begin
         if (cur_ph >= 0) runs.push_back(cur_len);
         cur_ph  = ph;
         cur_len = 1;
      end
   endtask

   task automatic flush();
      if (cur_ph >= 0) runs.push_back(cur_len);
      cur_ph  = -1;
      cur_len = 0;
   endtask

   task automatic clear_runs();
      runs.delete();
      cur_ph    = -1;
      cur_len   = 0;
      prev_addr = 16'd0;
   endtask

   // one clock: drive at negedge, classify the q_en tick by the audible phase, sample after posedge
   task automatic step();
      @(negedge clk);
      if (!relay) skip = 0;
      if (relay && !relay_prev) begin
         skip = DLY_Q;
         gap  = 0;
      end
      relay_prev = relay;
      q_en = (gap >= 4) && (gap >= 7 || $urandom_range(0, 3) == 0);
      gap  = q_en ? 1 : gap + 1;
      #1;
      if (q_en) begin
         qcnt++;
         if (skip > 0) begin
            chk("delay_quiet", casdout, 0);
            skip--;
         end else if (casdout) begin
            record(1);
         end else if (playing) begin
            record(0);
         end
      end
      @(posedge clk);
      #1;
      if (rd_addr != prev_addr) begin
         if (rd_addr != 16'd0) begin
            chk("addr_step", rd_addr, prev_addr + 16'd1);
            chk("byte_cadence", runs.size() + ((cur_ph >= 0) ? 1 : 0), 16 * rd_addr);
         end
         prev_addr = rd_addr;
      end
   endtask

   task automatic play_to_eot(input int budget);
      int n = 0;
      while (eot !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("eot_reached", eot, 1);
   endtask

   task automatic load_tape(input logic [7:0] bytes[$]);
      relay   = 1'b0;
      loading = 1'b1;
      step();
      step();
      foreach (bytes[k]) mem[k] = bytes[k];
      tape_len = 16'(bytes.size());
      chk("loading_idle", playing, 0);
      loading = 1'b0;
      step();
      clear_runs();
   endtask

   // expected half-cycle lengths straight from the bit values, LSB first
   task automatic check_runs(input logic [7:0] bytes[$]);
      int         exp_q[$];
      logic [7:0] b;
      flush();
      foreach (bytes[k]) begin
         b = bytes[k];
         for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i] ? HALF1 : HALF0);
            exp_q.push_back(b[i] ? HALF1 : HALF0);
         end
      end
      chk("run_count", runs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < runs.size(); i++)
         chk($sformatf("half_len[%0d]", i), runs[i], exp_q[i]);
   endtask

   initial begin
      logic [7:0]  tape[$];
      logic [15:0] a;
      int          n, bad, q0;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      repeat (3) step();
      chk("reset_addr", rd_addr, 0);
      chk("reset_casdout", casdout, 0);
      chk("reset_playing", playing, 0);
      chk("reset_eot", eot, 0);
      rst_n = 1'b1;
      step();

      relay = 1'b1;
      repeat (60) step();
      chk("empty_playing", playing, 0);
      chk("empty_addr", rd_addr, 0);
      chk("empty_casdout", casdout, 0);
      relay = 1'b0;
      step();

      tape = '{8'h00};
      load_tape(tape);
      relay = 1'b1;
      play_to_eot(6000);
      check_runs(tape);
      chk("eot_addr", rd_addr, 1);
      chk("eot_casdout", casdout, 0);
      repeat (40) step();
      chk("eot_hold_addr", rd_addr, 1);
      chk("eot_hold_flag", eot, 1);

      rewind = 1'b1;
      step();
      chk("rew_eot_addr", rd_addr, 0);
      chk("rew_eot_flag", eot, 0);
      chk("rew_eot_playing", playing, 0);
      step();
      rewind = 1'b0;
      clear_runs();
      play_to_eot(6000);
      check_runs(tape);

      tape = '{8'hFF, 8'hA5};
      load_tape(tape);
      relay = 1'b1;
      play_to_eot(12000);
      check_runs(tape);
      chk("ffa5_addr", rd_addr, 2);

      tape = '{8'h55, 8'hAA, 8'h3C};
      load_tape(tape);
      relay = 1'b1;
      play_to_eot(16000);
      check_runs(tape);
      chk("three_addr", rd_addr, 3);

      tape = '{8'($urandom), 8'($urandom), 8'($urandom)};
      load_tape(tape);
      relay = 1'b1;
      n = 0;
      while (!(runs.size() == 6 && cur_ph == 1 && cur_len == 1) && n < 5000) begin
         step();
         n++;
      end
      chk("pause_point", runs.size(), 6);
      a = rd_addr;
      relay = 1'b0;
      bad = 0;
      repeat (300) begin
         step();
         if (casdout !== 1'b0 || playing !== 1'b0) bad++;
      end
      chk("pause_quiet", bad, 0);
      chk("pause_addr", rd_addr, a);
      relay = 1'b1;
      play_to_eot(16000);
      check_runs(tape);

      tape = '{8'($urandom), 8'($urandom)};
      load_tape(tape);
      relay = 1'b1;
      n = 0;
      while (runs.size() < 20 && n < 8000) begin
         step();
         n++;
      end
      chk("midbyte_point", rd_addr, 1);
      rewind = 1'b1;
      step();
      chk("rew_mid_addr", rd_addr, 0);
      chk("rew_mid_eot", eot, 0);
      chk("rew_mid_playing", playing, 0);
      chk("rew_mid_casdout", casdout, 0);
      step();
      rewind = 1'b0;
      clear_runs();
      play_to_eot(12000);
      check_runs(tape);

      tape = '{8'h01};
      load_tape(tape);
      q0 = qcnt;
      relay = 1'b1;
      n = 0;
      while (casdout !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
      chk("first_rise_q", qcnt - q0, DLY_Q);
      play_to_eot(6000);
      check_runs(tape);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
